// File: rtl/flit_depacketizer.sv
// flit_depacketizer: reassembles one head/body.../tail flit packet into
// source ID, destination ID and a (14*N-8)-bit payload. Malformed flit
// sequences are dropped, flagged with a one-cycle pulse and counted.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a head flit
// BODY  | head seen, expecting body number body_cnt (1..N-2)
// TAIL  | all bodies seen, expecting the tail flit
module flit_depacketizer #(
    parameter int N = 4,
    localparam int W = 14*N-8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  flit_in,
    input  logic         flit_valid,
    output logic         flit_ready,
    output logic [3:0]   pkt_src,
    output logic [3:0]   pkt_des,
    output logic [W-1:0] pkt_data,
    output logic         pkt_valid,
    input  logic         pkt_ready,
    output logic         pkt_error,
    output logic [7:0]   err_count
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BODY = CW'(N-2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } state_t;

    // With only two flits per packet there is no body phase.
    localparam state_t AFTER_HEAD = (N > 2) ? BODY : TAIL;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_ILL  = 2'b11;

    state_t        state, nxt_state;
    logic [CW-1:0] body_cnt;
    logic [3:0]    stage_src;
    logic [3:0]    stage_des;
    logic [W-1:0]  stage_data;
    logic [1:0]    ftype;
    logic          accept;
    logic          err;
    logic          ld_head;
    logic          ld_body;
    logic          ld_tail;

    assign ftype      = flit_in[15:14];
    // A tail may only land when the output slot is free; depends on registers only.
    assign flit_ready = !(state == TAIL && pkt_valid);
    assign accept     = flit_valid && flit_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    // Next-state decode and per-flit load/error strobes.
    always_comb begin
        nxt_state = state;
        err       = 1'b0;
        ld_head   = 1'b0;
        ld_body   = 1'b0;
        ld_tail   = 1'b0;
        if (accept) begin
            if (ftype == T_ILL) begin
                err       = 1'b1;
                nxt_state = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ftype == T_HEAD) begin
                            ld_head   = 1'b1;
                            nxt_state = AFTER_HEAD;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    BODY: begin
                        if (ftype == T_HEAD) begin
                            err       = 1'b1;
                            ld_head   = 1'b1;
                            nxt_state = AFTER_HEAD;
                        end else if (ftype == T_BODY) begin
                            ld_body   = 1'b1;
                            nxt_state = (body_cnt == LAST_BODY) ? TAIL : BODY;
                        end else begin
                            err       = 1'b1;
                            nxt_state = IDLE;
                        end
                    end
                    TAIL: begin
                        if (ftype == T_HEAD) begin
                            err       = 1'b1;
                            ld_head   = 1'b1;
                            nxt_state = AFTER_HEAD;
                        end else if (ftype == T_TAIL) begin
                            ld_tail   = 1'b1;
                            nxt_state = IDLE;
                        end else begin
                            err       = 1'b1;
                            nxt_state = IDLE;
                        end
                    end
                    default: begin
                        err       = 1'b1;
                        nxt_state = IDLE;
                    end
                endcase
            end
        end
    end

    // Body counter and staging register fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            body_cnt   <= '0;
            stage_src  <= '0;
            stage_des  <= '0;
            stage_data <= '0;
        end else begin
            if (ld_head)      body_cnt <= CW'(1);
            else if (ld_body) body_cnt <= body_cnt + 1'b1;
            else if (accept)  body_cnt <= '0;

            if (ld_head) begin
                stage_src            <= flit_in[13:10];
                stage_des            <= flit_in[9:6];
                stage_data[W-1:W-6]  <= flit_in[5:0];
            end
            if (ld_body) begin
                for (int k = 1; k <= N-2; k++) begin
                    if (body_cnt == CW'(k)) stage_data[14*(N-k)-1 -: 14] <= flit_in[13:0];
                end
            end
            if (ld_tail) stage_data[13:0] <= flit_in[13:0];
        end
    end

    // Output slot: loaded on tail, released on consumer handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            pkt_src   <= '0;
            pkt_des   <= '0;
            pkt_data  <= '0;
        end else if (ld_tail) begin
            pkt_valid <= 1'b1;
            pkt_src   <= stage_src;
            pkt_des   <= stage_des;
            pkt_data  <= {stage_data[W-1:14], flit_in[13:0]};
        end else if (pkt_valid && pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_error <= 1'b0;
            err_count <= '0;
        end else begin
            pkt_error <= err;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule
